phy_rx_deserializador: RTL and testbench

Receive-side counterpart of `phy_tx`. It takes the single serial bit stream produced by the transmitter's parallel-to-serial stage and finds byte alignment on the comma/idle character 0xBC. It declares the link active after consecutive aligned commas, then rebuilds the bytes. Each byte is presented with a valid flag and a round-robin lane tag that downstream demux logic uses to rebuild `Salida0..3` / `validSalida0..3`.

---
 rtl/phy_rx_deserializador.sv | 138 +++++++++++++
 tb/tb_phy_rx_deserializador.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/phy_rx_deserializador.sv
// Serial receive deserializer: finds byte alignment on the comma character,
// declares the link active after BC_LOCK aligned commas, then emits lane-tagged bytes.
module phy_rx_deserializador #(
    parameter logic [7:0]  COMMA   = 8'hBC,
    parameter int unsigned BC_LOCK = 4
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       byte_strobe,
    output logic       valid_out,
    output logic [1:0] lane_out,
    output logic       active
);

    typedef enum logic [1:0] {
        ST_SEARCH,
        ST_ALIGN,
        ST_ACTIVE
    } state_t;

    localparam logic [3:0] LOCK_CNT = 4'(BC_LOCK);

    state_t     state_q, state_d;
    // Only the seven most recent bits are ever observed; the oldest bit of the
    // eight-bit history would be shifted out before it could be compared.
    logic [6:0] sr_q;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [3:0] bc_cnt_q, bc_cnt_d;
    logic [1:0] lane_cnt_q, lane_cnt_d;

    logic [7:0] data_d;
    logic [1:0] lane_d;
    logic       strobe_d;
    logic       valid_d;
    logic       active_d;

    logic [7:0] w;
    logic       is_comma;
    logic       byte_done;

    assign w         = {sr_q, data_in};
    assign is_comma  = (w == COMMA);
    assign byte_done = (bit_cnt_q == 3'd7);

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no branch can
        // leave one unassigned and infer a latch.
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q + 3'd1;
        bc_cnt_d   = bc_cnt_q;
        lane_cnt_d = lane_cnt_q;
        data_d     = data_out;
        lane_d     = lane_out;
        strobe_d   = 1'b0;
        valid_d    = 1'b0;
        active_d   = active;

        case (state_q)
            ST_SEARCH: begin
                // A match lands on the byte boundary, so the next bit is an MSB.
                bit_cnt_d = 3'd0;
                if (is_comma) begin
                    bc_cnt_d = 4'd1;
                    if (LOCK_CNT == 4'd1) begin
                        state_d    = ST_ACTIVE;
                        active_d   = 1'b1;
                        lane_cnt_d = 2'd0;
                    end else begin
                        state_d = ST_ALIGN;
                    end
                end
            end

            ST_ALIGN: begin
                if (byte_done) begin
                    if (is_comma) begin
                        bc_cnt_d = bc_cnt_q + 4'd1;
                        if (bc_cnt_q + 4'd1 == LOCK_CNT) begin
                            state_d    = ST_ACTIVE;
                            active_d   = 1'b1;
                            lane_cnt_d = 2'd0;
                        end
                    end else begin
                        // Partial lock is discarded; already-shifted bits stay in sr.
                        state_d  = ST_SEARCH;
                        bc_cnt_d = 4'd0;
                    end
                end
            end

            ST_ACTIVE: begin
                if (byte_done) begin
                    data_d     = w;
                    lane_d     = lane_cnt_q;
                    strobe_d   = 1'b1;
                    valid_d    = ~is_comma;
                    // Idle commas still consume a lane slot to track the TX round robin.
                    lane_cnt_d = lane_cnt_q + 2'd1;
                end
            end

            default: begin
                state_d = ST_SEARCH;
            end
        endcase
    end

    always_ff @(posedge clk_32f) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values, independent of statement order.
        if (reset) begin
            state_q     <= ST_SEARCH;
            sr_q        <= '0;
            bit_cnt_q   <= '0;
            bc_cnt_q    <= '0;
            lane_cnt_q  <= '0;
            data_out    <= '0;
            lane_out    <= '0;
            byte_strobe <= 1'b0;
            valid_out   <= 1'b0;
            active      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= w[6:0];
            bit_cnt_q   <= bit_cnt_d;
            bc_cnt_q    <= bc_cnt_d;
            lane_cnt_q  <= lane_cnt_d;
            data_out    <= data_d;
            lane_out    <= lane_d;
            byte_strobe <= strobe_d;
            valid_out   <= valid_d;
            active      <= active_d;
        end
    end

endmodule

// File: tb/tb_phy_rx_deserializador.sv
// Self-checking bench: stream-level reference model feeding a per-cycle vector
// table, plus hand-written reset-in-active and single-comma-lock sequences.
module tb_phy_rx_deserializador;

    localparam logic [7:0]  COMMA   = 8'hBC;
    localparam int unsigned BC_LOCK = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       din = 1'b0;

    logic [7:0] data_out, data_out1;
    logic       byte_strobe, byte_strobe1;
    logic       valid_out, valid_out1;
    logic [1:0] lane_out, lane_out1;
    logic       active, active1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    phy_rx_deserializador #(.COMMA(COMMA), .BC_LOCK(BC_LOCK)) dut (
        .clk_32f     (clk),
        .reset       (reset),
        .data_in     (din),
        .data_out    (data_out),
        .byte_strobe (byte_strobe),
        .valid_out   (valid_out),
        .lane_out    (lane_out),
        .active      (active)
    );

    // Second instance exercising the single-comma lock boundary.
    phy_rx_deserializador #(.COMMA(COMMA), .BC_LOCK(1)) dut1 (
        .clk_32f     (clk),
        .reset       (reset),
        .data_in     (din),
        .data_out    (data_out1),
        .byte_strobe (byte_strobe1),
        .valid_out   (valid_out1),
        .lane_out    (lane_out1),
        .active      (active1)
    );

    typedef struct {
        bit       rst;
        bit       din;
        bit       e_active;
        bit       e_strobe;
        bit       e_valid;
        bit [7:0] e_data;
        bit [1:0] e_lane;
    } vec_t;

    vec_t vecs[$];
    bit   stream[$];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    function automatic void push_byte(input bit [7:0] b);
        for (int k = 7; k >= 0; k--) stream.push_back(b[k]);
    endfunction

    function automatic void add_reset(input int n);
        for (int k = 0; k < n; k++)
            vecs.push_back('{1'b1, 1'($urandom), 1'b0, 1'b0, 1'b0, 8'h00, 2'd0});
    endfunction

    // Reference model over the whole post-reset bit stream: find the first comma
    // window, then expect commas every 8 bits until BC_LOCK of them; after that
    // every 8th bit closes a byte with a round-robin lane.
    function automatic void add_session();
        bit       searching = 1'b1;
        bit       act = 1'b0;
        int       cnt = 0;
        int       next_boundary = -1;
        int       lane = 0;
        bit [7:0] data = 8'h00;
        bit [1:0] lane_o = 2'd0;
        bit [7:0] win;
        bit       strobe, valid;
        for (int i = 0; i < stream.size(); i++) begin
            win = 8'h00;
            for (int k = 0; k < 8; k++)
                if (i - 7 + k >= 0) win[7-k] = stream[i-7+k];
            strobe = 1'b0;
            valid  = 1'b0;
            if (act) begin
                if (i == next_boundary) begin
                    strobe = 1'b1;
                    valid  = (win != COMMA);
                    data   = win;
                    lane_o = 2'(lane);
                    lane   = (lane + 1) % 4;
                    next_boundary += 8;
                end
            end else if (searching) begin
                if (win == COMMA) begin
                    cnt = 1;
                    next_boundary = i + 8;
                    if (cnt == int'(BC_LOCK)) begin
                        act  = 1'b1;
                        lane = 0;
                    end else begin
                        searching = 1'b0;
                    end
                end
            end else if (i == next_boundary) begin
                if (win == COMMA) begin
                    cnt++;
                    next_boundary += 8;
                    if (cnt == int'(BC_LOCK)) begin
                        act  = 1'b1;
                        lane = 0;
                    end
                end else begin
                    searching = 1'b1;
                    cnt = 0;
                end
            end
            vecs.push_back('{1'b0, stream[i], act, strobe, valid, data, lane_o});
        end
        stream.delete();
    endfunction

    task automatic step(input bit r, input bit d);
        reset = r;
        din   = d;
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input bit [7:0] b);
        for (int k = 7; k >= 0; k--) step(1'b0, b[k]);
    endtask

    initial begin
        int nrand;

        // Lock after 3 random bits, then data with lane wrap.
        add_reset(2);
        for (int k = 0; k < 3; k++) stream.push_back(1'($urandom));
        repeat (4) push_byte(COMMA);
        push_byte(8'h11); push_byte(COMMA); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44);
        add_session();

        // Broken lock: partial comma count is discarded.
        add_reset(2);
        push_byte(COMMA); push_byte(COMMA); push_byte(8'h55);
        repeat (4) push_byte(COMMA);
        push_byte(8'h5A); push_byte(8'hC3);
        add_session();

        // Misalignment by 5 bit positions.
        add_reset(1);
        stream.push_back(1'b0); stream.push_back(1'b1); stream.push_back(1'b0);
        stream.push_back(1'b0); stream.push_back(1'b1);
        repeat (4) push_byte(COMMA);
        push_byte(8'hA5);
        add_session();

        // No false lock on 0x00 / 0xFF runs.
        add_reset(1);
        repeat (40) push_byte($urandom_range(0, 1) == 0 ? 8'h00 : 8'hFF);
        add_session();

        // Randomized sessions.
        for (int s = 0; s < 6; s++) begin
            add_reset(1 + $urandom_range(0, 1));
            nrand = $urandom_range(0, 7);
            for (int k = 0; k < nrand; k++) stream.push_back(1'($urandom));
            nrand = ($urandom_range(0, 1) == 0) ? 4 : $urandom_range(0, 5);
            repeat (nrand) push_byte(COMMA);
            repeat (24) push_byte(($urandom_range(0, 3) == 0) ? COMMA : 8'($urandom));
            add_session();
        end

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].din);
            check($sformatf("v%0d active", i), 32'(active), 32'(vecs[i].e_active));
            check($sformatf("v%0d strobe", i), 32'(byte_strobe), 32'(vecs[i].e_strobe));
            check($sformatf("v%0d valid", i), 32'(valid_out), 32'(vecs[i].e_valid));
            check($sformatf("v%0d data", i), 32'(data_out), 32'(vecs[i].e_data));
            check($sformatf("v%0d lane", i), 32'(lane_out), 32'(vecs[i].e_lane));
        end

        // Reset in the middle of a byte while active.
        step(1'b1, 1'b0); step(1'b1, 1'b0);
        repeat (4) send_byte(COMMA);
        check("hand lock active", 32'(active), 32'd1);
        check("hand lock no strobe", 32'(byte_strobe), 32'd0);
        send_byte(8'h12);
        check("hand b0 strobe", 32'(byte_strobe), 32'd1);
        check("hand b0 lane", 32'(lane_out), 32'd0);
        send_byte(8'h34);
        check("hand b1 data", 32'(data_out), 32'h34);
        check("hand b1 lane", 32'(lane_out), 32'd1);
        step(1'b0, 1'b0); step(1'b0, 1'b1); step(1'b0, 1'b1); step(1'b0, 1'b0);
        step(1'b1, 1'b1);
        check("rst active", 32'(active), 32'd0);
        check("rst data", 32'(data_out), 32'h00);
        check("rst strobe", 32'(byte_strobe), 32'd0);
        check("rst valid", 32'(valid_out), 32'd0);
        check("rst lane", 32'(lane_out), 32'd0);
        repeat (4) send_byte(COMMA);
        check("relock active", 32'(active), 32'd1);
        send_byte(8'h66);
        check("relock strobe", 32'(byte_strobe), 32'd1);
        check("relock valid", 32'(valid_out), 32'd1);
        check("relock data", 32'(data_out), 32'h66);
        check("relock lane", 32'(lane_out), 32'd0);
        step(1'b0, 1'b0);
        check("relock strobe fall", 32'(byte_strobe), 32'd0);
        check("relock data hold", 32'(data_out), 32'h66);

        // Single-comma lock on the BC_LOCK=1 instance.
        step(1'b1, 1'b0); step(1'b1, 1'b0);
        send_byte(COMMA);
        check("lock1 active", 32'(active1), 32'd1);
        check("lock1 no strobe", 32'(byte_strobe1), 32'd0);
        check("lock4 not active", 32'(active), 32'd0);
        send_byte(8'h42);
        check("lock1 strobe", 32'(byte_strobe1), 32'd1);
        check("lock1 valid", 32'(valid_out1), 32'd1);
        check("lock1 data", 32'(data_out1), 32'h42);
        check("lock1 lane", 32'(lane_out1), 32'd0);
        send_byte(COMMA);
        check("lock1 comma strobe", 32'(byte_strobe1), 32'd1);
        check("lock1 comma valid", 32'(valid_out1), 32'd0);
        check("lock1 comma lane", 32'(lane_out1), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
